// File: rtl/evt_burst_gen.sv
// evt_burst_gen: programmable event-burst generator. On an accepted start it emits
// N single-cycle strobes spaced P cycles apart and pulses done with the last one.
// Latency: first strobe visible right after the accepting edge; all outputs registered.
// Backpressure: none; start is ignored while a burst runs and abort terminates it at once.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   start_in, abort_in    burst request / terminate request (sampled on rising edge)
//   period_in, count_in   period P (0 treated as 1) and event count N (0..MAX_COUNT)
//   evt_out, evt_index_out  event strobe and its 0-based index (0 when no strobe)
//   busy_out, done_out    burst in progress / one-cycle completion pulse
module evt_burst_gen #(
  parameter int MAX_PERIOD = 1024,
  parameter int MAX_COUNT  = 1024
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start_in,
  input  logic [$clog2(MAX_PERIOD)-1:0]    period_in,
  input  logic [$clog2(MAX_COUNT+1)-1:0]   count_in,
  input  logic                             abort_in,
  output logic                             evt_out,
  output logic [$clog2(MAX_COUNT)-1:0]     evt_index_out,
  output logic                             busy_out,
  output logic                             done_out
);

  localparam int PW = $clog2(MAX_PERIOD);
  localparam int NW = $clog2(MAX_COUNT+1);
  localparam int IW = $clog2(MAX_COUNT);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          r_state,   w_state_nxt;
  logic [PW-1:0]   r_period,  w_period_nxt;
  logic [PW-1:0]   r_timer,   w_timer_nxt;
  logic [NW-1:0]   r_count,   w_count_nxt;
  logic [IW-1:0]   r_evt_cnt, w_evt_cnt_nxt;
  logic            r_evt,     w_evt_nxt;
  logic [IW-1:0]   r_index,   w_index_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;

  logic [PW-1:0]   w_period_eff;
  logic [PW-1:0]   w_period_m1;
  logic [NW-1:0]   w_count_m1;
  logic [IW-1:0]   w_next_idx;
  logic            w_timer_wrap;
  logic            w_last_due;

  assign w_period_eff = (period_in == '0) ? PW'(1) : period_in;
  assign w_period_m1  = r_period - PW'(1);
  assign w_count_m1   = r_count - NW'(1);
  assign w_next_idx   = r_evt_cnt + IW'(1);
  assign w_timer_wrap = (r_timer == w_period_m1);
  assign w_last_due   = (NW'(w_next_idx) == w_count_m1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_period  <= '0;
      r_timer   <= '0;
      r_count   <= '0;
      r_evt_cnt <= '0;
      r_evt     <= 1'b0;
      r_index   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_timer   <= w_timer_nxt;
      r_count   <= w_count_nxt;
      r_evt_cnt <= w_evt_cnt_nxt;
      r_evt     <= w_evt_nxt;
      r_index   <= w_index_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_period_nxt  = r_period;
    w_timer_nxt   = r_timer;
    w_count_nxt   = r_count;
    w_evt_cnt_nxt = r_evt_cnt;
    w_evt_nxt     = 1'b0;
    w_index_nxt   = '0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        // Abort in IDLE suppresses a coincident start.
        if (start_in && !abort_in) begin
          if (count_in == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = RUN;
            w_period_nxt  = w_period_eff;
            w_count_nxt   = count_in;
            w_timer_nxt   = '0;
            w_evt_cnt_nxt = '0;
            w_evt_nxt     = 1'b1;
            w_busy_nxt    = 1'b1;
            w_done_nxt    = (count_in == NW'(1));
          end
        end
      end

      RUN: begin
        // In RUN, r_done marks the final event; the following edge leaves RUN.
        if (abort_in || r_done) begin
          w_state_nxt   = IDLE;
          w_timer_nxt   = '0;
          w_evt_cnt_nxt = '0;
        end else begin
          w_busy_nxt = 1'b1;
          if (w_timer_wrap) begin
            w_timer_nxt   = '0;
            w_evt_cnt_nxt = w_next_idx;
            w_evt_nxt     = 1'b1;
            w_index_nxt   = w_next_idx;
            w_done_nxt    = w_last_due;
          end else begin
            w_timer_nxt = r_timer + PW'(1);
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign evt_out       = r_evt;
  assign evt_index_out = r_index;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Directed bench for evt_burst_gen with small parameters (MAX_PERIOD=16, MAX_COUNT=8).
// Each check compares {evt, index, busy, done} one time unit after the rising edge.
module tb_evt_burst_gen;

  logic       clk_in;
  logic       rst_in;
  logic       start_in;
  logic [3:0] period_in;
  logic [3:0] count_in;
  logic       abort_in;
  logic       evt_out;
  logic [2:0] evt_index_out;
  logic       busy_out;
  logic       done_out;

  int checks = 0;
  int passes = 0;

  evt_burst_gen #(.MAX_PERIOD(16), .MAX_COUNT(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .period_in     (period_in),
    .count_in      (count_in),
    .abort_in      (abort_in),
    .evt_out       (evt_out),
    .evt_index_out (evt_index_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input logic e, input logic [2:0] ix,
                     input logic b, input logic d);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {evt_out, evt_index_out, busy_out, done_out};
    exp = {e, ix, b, d};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d evt/idx/busy/done got %b expected %b", tag, j, obs, exp);
  endtask

  // Start a burst and follow it until busy has dropped, using the timing rules:
  // strobes at j = 0, P, .., (N-1)P; done at (N-1)P; busy through (N-1)P.
  task automatic burst(input string tag, input int pin, input int peff, input int n);
    int   last;
    logic e;
    last = (n - 1) * peff + 1;
    period_in = pin[3:0];
    count_in  = n[3:0];
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    for (int j = 0; j <= last; j++) begin
      e = ((j % peff) == 0) && ((j / peff) < n);
      chk(tag, j, e, e ? 3'(j / peff) : 3'd0, j <= (n - 1) * peff, j == (n - 1) * peff);
      if (j != last) tick();
    end
  endtask

  initial begin
    logic e;
    rst_in    = 1'b1;
    start_in  = 1'b0;
    period_in = '0;
    count_in  = '0;
    abort_in  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_hold", 0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_in = 1'b0;
    tick();
    chk("reset_release", 0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Basic burst P=3 N=4
    burst("basic_p3_n4", 3, 3, 4);

    // Degenerate periods: 0 and 1 both give back-to-back strobes
    burst("period0_n5", 0, 1, 5);
    burst("period1_n5", 1, 1, 5);

    // Ignored inputs: P=4 N=3, start and period change mid-burst, start on exit edge
    period_in = 4'd4;
    count_in  = 4'd3;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      e = ((j % 4) == 0);
      chk("ignore_mid", j, e, e ? 3'(j / 4) : 3'd0, 1'b1, j == 8);
      if (j == 2) begin
        start_in  = 1'b1;
        period_in = 4'd7;
      end
      if (j == 3) start_in = 1'b0;
      if (j == 8) begin
        start_in  = 1'b1;
        period_in = 4'd1;
        count_in  = 4'd2;
      end
      tick();
    end
    chk("ignore_exit_start", 9, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    start_in = 1'b0;
    chk("accept_after_exit", 0, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    chk("accept_after_exit", 1, 1'b1, 3'd1, 1'b1, 1'b1);
    tick();
    chk("accept_after_exit", 2, 1'b0, 3'd0, 1'b0, 1'b0);

    // Abort on the edge the third event is due (P=2 N=6)
    period_in = 4'd2;
    count_in  = 4'd6;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    for (int j = 0; j <= 3; j++) begin
      e = ((j % 2) == 0);
      chk("abort_pre", j, e, e ? 3'(j / 2) : 3'd0, 1'b1, 1'b0);
      if (j == 3) abort_in = 1'b1;
      tick();
    end
    abort_in = 1'b0;
    chk("abort_edge", 4, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("abort_after", 5, 1'b0, 3'd0, 1'b0, 1'b0);
    burst("after_abort_n2", 3, 3, 2);

    // Abort together with start in IDLE: nothing happens
    period_in = 4'd1;
    count_in  = 4'd3;
    start_in  = 1'b1;
    abort_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    abort_in  = 1'b0;
    chk("abort_beats_start", 0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("abort_beats_start", 1, 1'b0, 3'd0, 1'b0, 1'b0);

    // count_in = 0: single done pulse only
    period_in = 4'd3;
    count_in  = 4'd0;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    chk("count0_done", 0, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("count0_after", 1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Single-event burst: done with the only strobe
    burst("single_n1", 5, 5, 1);

    // Max boundaries: N=MAX_COUNT, P=MAX_PERIOD-1
    burst("max_p15_n8", 15, 15, 8);

    // Asynchronous reset mid-burst
    period_in = 4'd3;
    count_in  = 4'd4;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    chk("rst_mid_pre", 0, 1'b1, 3'd0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("rst_mid_pre", 3, 1'b1, 3'd1, 1'b1, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("rst_async", 3, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("rst_held", 4, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_in = 1'b0;
    for (int j = 5; j <= 10; j++) begin
      tick();
      chk("rst_released", j, 1'b0, 3'd0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/evt_burst_gen.md
# evt_burst_gen

Programmable event-burst generator: on a start request it emits a fixed number of single-cycle event strobes spaced a programmable number of cycles apart, then signals completion. It is the producing end of the event-strobe interface consumed by `evt_counter`. Used to pace capture triggers, line strobes and test stimulus in the controller FPGA. It also serves as a self-check source for counters on that interface.

## Interface
- `MAX_PERIOD`, default 1024: exclusive upper bound on the programmable period.
- `MAX_COUNT`, default 1024: maximum events per burst, inclusive.
- `clk_in` input 1: system clock; all logic is on its rising edge.
- `rst_in` input 1: reset, asynchronous and active-high.
- `start_in` input 1: burst request, sampled on the rising edge.
- `period_in` input $clog2(MAX_PERIOD): cycles between events. Value 0 is treated as 1.
- `count_in` input $clog2(MAX_COUNT+1): events in the burst, 0..MAX_COUNT.
- `abort_in` input 1: terminate the burst in progress.
- `evt_out` output 1: single-cycle event strobe.
- `evt_index_out` output $clog2(MAX_COUNT): 0-based index of the current event. Valid only while `evt_out`=1; 0 otherwise.
- `busy_out` output 1: burst in progress.
- `done_out` output 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `busy_out`=0.
  - RUN: `busy_out`=1.
- All outputs are registered.
- Reset values: state IDLE; `evt_out`, `evt_index_out`, `busy_out` and `done_out` are all 0. The period timer and event counter are also 0.
- IDLE, `start_in`=1, `abort_in`=0, `count_in`≥1:
  - Latch P = max(`period_in`,1) and N = `count_in`.
  - Enter RUN.
  - Issue event 0 on the same edge.
- IDLE, `start_in`=1, `count_in`=0: no events, stay IDLE, `done_out` pulses for one cycle.
- RUN:
  - Period timer counts 0..P-1 and wraps.
  - On each wrap, issue the next event; `evt_index_out` increments by 1.
- Final event (index N-1):
  - `done_out`=1 in the same cycle as that `evt_out`.
  - The next edge returns to IDLE.
- `start_in` is ignored while in RUN, including the edge that exits RUN. No queuing.
- `period_in` and `count_in` changes during RUN have no effect; values are latched at start.
- `abort_in`=1 sampled in RUN:
  - Next state IDLE.
  - No event is issued on that edge, even if one was due.
  - `done_out` stays 0.
  - Internal counters clear.
- `abort_in`=1 together with `start_in` in IDLE: abort wins; start is ignored.
- Asynchronous reset mid-burst: all outputs go to reset values immediately, with no `done_out`.
- Counter widths must hold N=MAX_COUNT and P=MAX_PERIOD-1 without overflow. Event index never exceeds N-1.

## Timing
- Start accepted at edge k. `evt_out` is high in the cycles following edges k, k+P, k+2P … k+(N-1)P.
- Latency from start edge to first strobe: 0 edges, i.e. visible immediately after the accepting edge.
- `busy_out` rises at edge k and falls at edge k+(N-1)P+1.
- Earliest next accepted start: edge k+(N-1)P+2.
- P=1 gives N back-to-back strobe cycles with no gaps.
- `done_out` and the last `evt_out` are coincident, each one cycle wide.
- Compatibility with `evt_counter`: when N equals that counter's MAX_COUNT, its `hit_max` pulses one cycle after the final `evt_out`, and its `count_out` returns to 0.
- Abort sampled at edge a: `busy_out`=0 and `evt_out`=0 from edge a.

## Test plan
- Reset: assert `rst_in` asynchronously mid-cycle → all outputs read 0 immediately and after release, with no spurious `evt_out`.
- Basic burst, `period_in`=3, `count_in`=4, start at edge k:
  - `evt_out` at k, k+3, k+6, k+9 with indices 0,1,2,3.
  - `done_out` only at k+9.
  - `busy_out` low from k+10.
  - An `evt_counter` with MAX_COUNT=4 on `evt_out` shows `hit_max` at k+10 and `count_out`=0.
- Degenerate periods: `period_in`=0 and then 1, `count_in`=5 → five consecutive `evt_out` cycles each time, indices 0..4, `done_out` on the fifth.
- Ignored inputs, burst P=4, N=3:
  - Pulse `start_in` and change `period_in` to 7 mid-burst → spacing stays 4, still exactly 3 events.
  - `start_in` on the exit edge is ignored.
  - `start_in` one edge later is accepted.
- Abort: P=2, N=6, assert `abort_in` on the edge the third event is due → exactly 2 events, no `done_out`, `busy_out` drops that edge. A following start with N=2 runs normally with indices 0,1.
- Boundaries:
  - `count_in`=0 start → single `done_out`, no `evt_out`, `busy_out` stays 0.
  - `count_in`=MAX_COUNT, `period_in`=MAX_PERIOD-1 → MAX_COUNT events, last index MAX_COUNT-1, no overflow.
